microseq_ctrl: RTL

- Sequencer in front of microaddr_counter: decodes the next-address field of the current microinstruction into a microaddr_types::cmd and load_addr for the counter.
- Adds the sequencing policy the counter lacks: opcode dispatch, memory wait handshake with timeout, call-depth checking, halt/run and fault states.
- Sits between the microcode ROM (async read at counter addr) and microaddr_counter; also owns the counter's synchronous reset.

---
 rtl/microaddr_types.sv | 16 +
 rtl/microseq_pkg.sv | 33 +++
 rtl/microseq_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/microaddr_types.sv
// microaddr_types: shared micro-address width and counter command encoding
// used between the sequencer and microaddr_counter.
`default_nettype none
package microaddr_types;
    typedef logic [7:0] uaddr;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_INC    = 3'd1,
        CMD_LOAD   = 3'd2,
        CMD_LOADNE = 3'd3,
        CMD_CALL   = 3'd4,
        CMD_RET    = 3'd5
    } cmd;
endpackage
`default_nettype wire

// File: rtl/microseq_pkg.sv
// microseq_pkg: next-address opcodes, sequencer states, fault codes and the
// opcode dispatch table for microseq_ctrl.
`default_nettype none
package microseq_pkg;
    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'd0,
        SEQ_JUMP     = 3'd1,
        SEQ_JNZ      = 3'd2,
        SEQ_CALL     = 3'd3,
        SEQ_RET      = 3'd4,
        SEQ_DISPATCH = 3'd5,
        SEQ_WAIT     = 3'd6,
        SEQ_HALT     = 3'd7
    } seq_op_e;

    typedef enum logic [2:0] {
        ST_RST      = 3'd0,
        ST_RUN      = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_HALTED   = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    localparam logic [1:0] FC_NONE      = 2'd0;
    localparam logic [1:0] FC_OVERFLOW  = 2'd1;
    localparam logic [1:0] FC_UNDERFLOW = 2'd2;
    localparam logic [1:0] FC_TIMEOUT   = 2'd3;

    function automatic logic [7:0] dispatch_addr(input logic [3:0] opcode);
        return {2'b01, opcode, 2'b00};
    endfunction
endpackage
`default_nettype wire

// File: rtl/microseq_ctrl.sv
// microseq_ctrl: decodes the microinstruction next-address field into
// microaddr_counter commands; optional MICROSEQ_SINGLE_STEP_EN adds step gating.
`default_nettype none
module microseq_ctrl
    import microseq_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255,
    parameter int STACK_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            seq_op,
    input  microaddr_types::uaddr seq_target,
    input  logic [3:0]            opcode,
    input  logic                  zflag,
    input  logic                  mem_ack,
    input  logic                  run_req,
`ifdef MICROSEQ_SINGLE_STEP_EN
    input  logic                  step_mode,
    input  logic                  step_req,
`endif
    output microaddr_types::cmd   ctr_cmd,
    output microaddr_types::uaddr ctr_load_addr,
    output logic                  ctr_reset,
    output logic                  mem_req,
    output logic                  halted,
    output logic                  fault,
    output logic [1:0]            fault_code
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    state_e      r_state, w_state_nxt;
    logic [DW-1:0] r_depth, w_depth_nxt;
    logic [7:0]  r_timer, w_timer_nxt;
    logic [1:0]  r_fault_code, w_fc_nxt;

    // zflag is consumed by the counter, not by the sequencing policy
    logic w_unused_zflag;
    assign w_unused_zflag = zflag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RST;
            r_depth      <= '0;
            r_timer      <= '0;
            r_fault_code <= FC_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_depth      <= w_depth_nxt;
            r_timer      <= w_timer_nxt;
            r_fault_code <= w_fc_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_depth_nxt   = r_depth;
        w_timer_nxt   = r_timer;
        w_fc_nxt      = r_fault_code;
        ctr_cmd       = microaddr_types::CMD_NONE;
        ctr_load_addr = '0;
        ctr_reset     = 1'b0;
        mem_req       = 1'b0;
        halted        = 1'b0;
        fault         = 1'b0;
        case (r_state)
            ST_RST: begin
                ctr_reset   = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                case (seq_op_e'(seq_op))
                    SEQ_NEXT: ctr_cmd = microaddr_types::CMD_INC;
                    SEQ_JUMP: begin
                        ctr_cmd       = microaddr_types::CMD_LOAD;
                        ctr_load_addr = seq_target;
                    end
                    SEQ_JNZ: begin
                        ctr_cmd       = microaddr_types::CMD_LOADNE;
                        ctr_load_addr = seq_target;
                    end
                    SEQ_CALL: begin
                        if (r_depth == DW'(STACK_DEPTH)) begin
                            w_state_nxt = ST_FAULT;
                            w_fc_nxt    = FC_OVERFLOW;
                        end else begin
                            ctr_cmd       = microaddr_types::CMD_CALL;
                            ctr_load_addr = seq_target;
                            w_depth_nxt   = r_depth + DW'(1);
                        end
                    end
                    SEQ_RET: begin
                        if (r_depth == '0) begin
                            w_state_nxt = ST_FAULT;
                            w_fc_nxt    = FC_UNDERFLOW;
                        end else begin
                            ctr_cmd     = microaddr_types::CMD_RET;
                            w_depth_nxt = r_depth - DW'(1);
                        end
                    end
                    SEQ_DISPATCH: begin
                        ctr_cmd       = microaddr_types::CMD_LOAD;
                        ctr_load_addr = dispatch_addr(opcode);
                    end
                    SEQ_WAIT: begin
                        mem_req     = 1'b1;
                        w_timer_nxt = '0;
                        w_state_nxt = ST_WAIT_MEM;
                    end
                    SEQ_HALT: w_state_nxt = ST_HALTED;
                    default: begin
                        w_state_nxt = ST_FAULT;
                        w_fc_nxt    = FC_NONE;
                    end
                endcase
`ifdef MICROSEQ_SINGLE_STEP_EN
                // Hold any issuing decode until a step pulse; faulting decodes pass through
                if (step_mode && !step_req && ctr_cmd != microaddr_types::CMD_NONE) begin
                    ctr_cmd     = microaddr_types::CMD_NONE;
                    halted      = 1'b1;
                    w_depth_nxt = r_depth;
                end
`endif
            end
            ST_WAIT_MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ctr_cmd     = microaddr_types::CMD_INC;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                    if (r_timer + 8'd1 == 8'(WAIT_TIMEOUT)) begin
                        w_state_nxt = ST_FAULT;
                        w_fc_nxt    = FC_TIMEOUT;
                    end
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (run_req) begin
                    ctr_cmd     = microaddr_types::CMD_INC;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FAULT: fault = 1'b1;
            default: w_state_nxt = ST_FAULT;
        endcase
    end

    assign fault_code = r_fault_code;
endmodule
`default_nettype wire
